// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared encodings and helpers for the vending controller
package vending_pkg;

    // One-hot so the state register can drive state_led directly
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_CREDIT = 4'b0010,
        S_CHANGE = 4'b0100,
        S_VEND   = 4'b1000
    } state_e;

    localparam logic [1:0] BZ_NONE = 2'b00;
    localparam logic [1:0] BZ_OK   = 2'b01;
    localparam logic [1:0] BZ_ERR  = 2'b10;

    localparam logic [1:0] CS_COIN0   = 2'd0;
    localparam logic [1:0] CS_COIN1   = 2'd1;
    localparam logic [1:0] CS_COIN2   = 2'd2;
    localparam logic [1:0] CS_INVALID = 2'd3;

    function automatic int item_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vend_bin2bcd.sv
// rtl/vend_bin2bcd.sv - combinational binary to two-digit BCD (saturates at 99)
module vend_bin2bcd
    import vending_pkg::*;
#(
    parameter int BIN_W = 8
)(
    input  logic [BIN_W-1:0] bin_i,
    output logic [7:0]       bcd_o
);

    logic [7:0] acc;

    always_comb begin
        acc = '0;
        // Shift-and-add-3; two digits are enough because credit never exceeds 99
        for (int b = BIN_W - 1; b >= 0; b--) begin
            if (acc[3:0] >= 4'd5) acc[3:0] = acc[3:0] + 4'd3;
            if (acc[7:4] >= 4'd5) acc[7:4] = acc[7:4] + 4'd3;
            acc = {acc[6:0], bin_i[b]};
        end
        bcd_o = (32'(bin_i) > 32'd99) ? 8'h99 : acc;
    end

endmodule

// File: rtl/vending_fsm_gen.sv
// rtl/vending_fsm_gen.sv - parametrised vending controller: credit, vend, timeout refund, greedy change
module vending_fsm_gen
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int ITEM_W = item_w(NUM_ITEMS),
    parameter int PRICE_W = 8,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd20, 8'd12, 8'd7, 8'd3},
    parameter int COIN0 = 1,
    parameter int COIN1 = 5,
    parameter int COIN2 = 10,
    parameter int CREDIT_MAX = 99,
    parameter int TIMEOUT_CYC = 500_000_000
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_vld,
    input  logic [1:0]         coin_sel,
    input  logic               buy,
    input  logic [ITEM_W-1:0]  item_sel,
    input  logic               cancel,
    input  logic               chg_ack,
    output logic [PRICE_W-1:0] credit,
    output logic [7:0]         credit_bcd,
    output logic               vend_vld,
    output logic [ITEM_W-1:0]  vend_item,
    output logic               coin_rej,
    output logic               chg_vld,
    output logic [1:0]         chg_sel,
    output logic [1:0]         buzzer_en,
    output logic [3:0]         state_led
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SUM_W = PRICE_W + 1;

    state_e              state_q, state_d;
    logic [PRICE_W-1:0]  credit_q, credit_d;
    logic [ITEM_W-1:0]   item_q, item_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                vend_vld_q, vend_vld_d;
    logic [ITEM_W-1:0]   vend_item_q, vend_item_d;
    logic                coin_rej_q, coin_rej_d;
    logic                chg_vld_q, chg_vld_d;
    logic [1:0]          chg_sel_q, chg_sel_d;
    logic [1:0]          buzzer_q, buzzer_d;

    logic [SUM_W-1:0]    coin_sum;
    logic [PRICE_W-1:0]  buy_price;
    logic [PRICE_W-1:0]  vend_price;
    logic [PRICE_W-1:0]  chg_amt;
    logic                item_oob;
    logic                took_cmd;

    function automatic logic [PRICE_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            CS_COIN0: coin_value = PRICE_W'(COIN0);
            CS_COIN1: coin_value = PRICE_W'(COIN1);
            CS_COIN2: coin_value = PRICE_W'(COIN2);
            default:  coin_value = '0;
        endcase
    endfunction

    // Greedy change: largest denomination that still fits in the remaining credit
    function automatic logic [1:0] change_sel(input logic [PRICE_W-1:0] c);
        if (SUM_W'(c) >= SUM_W'(COIN2))      change_sel = CS_COIN2;
        else if (SUM_W'(c) >= SUM_W'(COIN1)) change_sel = CS_COIN1;
        else                                 change_sel = CS_COIN0;
    endfunction

    function automatic logic [PRICE_W-1:0] price_of(input logic [ITEM_W-1:0] item);
        price_of = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (item == ITEM_W'(k)) price_of = PRICES[k*PRICE_W +: PRICE_W];
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        item_d      = item_q;
        timer_d     = '0;
        vend_vld_d  = 1'b0;
        vend_item_d = vend_item_q;
        coin_rej_d  = 1'b0;
        buzzer_d    = BZ_NONE;
        took_cmd    = 1'b0;

        coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_value(coin_sel));
        buy_price  = price_of(item_sel);
        vend_price = price_of(item_q);
        chg_amt    = coin_value(chg_sel_q);
        item_oob   = ({1'b0, item_sel} >= (ITEM_W + 1)'(NUM_ITEMS));

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel && credit_q != '0) begin
                    state_d  = S_CHANGE;
                    took_cmd = 1'b1;
                end else if (buy) begin
                    if (item_oob || credit_q < buy_price) begin
                        buzzer_d = BZ_ERR;
                    end else begin
                        state_d  = S_VEND;
                        item_d   = item_sel;
                        took_cmd = 1'b1;
                    end
                end

                // A coin only credits when no command claimed this cycle
                if (coin_vld) begin
                    if (took_cmd) begin
                        coin_rej_d = 1'b1;
                    end else if (coin_sel == CS_INVALID || coin_sum > SUM_W'(CREDIT_MAX)) begin
                        coin_rej_d = 1'b1;
                        buzzer_d   = BZ_ERR;
                    end else begin
                        credit_d = coin_sum[PRICE_W-1:0];
                        state_d  = S_CREDIT;
                    end
                end

                if (state_q == S_CREDIT && state_d == S_CREDIT && !(coin_vld || buy || cancel)) begin
                    if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) state_d = S_CHANGE;
                    else                                     timer_d = timer_q + 1'b1;
                end
            end

            S_VEND: begin
                credit_d    = credit_q - vend_price;
                vend_vld_d  = 1'b1;
                vend_item_d = item_q;
                buzzer_d    = BZ_OK;
                coin_rej_d  = coin_vld;
                state_d     = (credit_d != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                coin_rej_d = coin_vld;
                if (chg_ack && chg_vld_q) begin
                    credit_d = credit_q - chg_amt;
                    if (credit_d == '0) state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        chg_vld_d = (state_d == S_CHANGE);
        chg_sel_d = chg_vld_d ? change_sel(credit_d) : CS_COIN0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            item_q      <= '0;
            timer_q     <= '0;
            vend_vld_q  <= 1'b0;
            vend_item_q <= '0;
            coin_rej_q  <= 1'b0;
            chg_vld_q   <= 1'b0;
            chg_sel_q   <= '0;
            buzzer_q    <= BZ_NONE;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            item_q      <= item_d;
            timer_q     <= timer_d;
            vend_vld_q  <= vend_vld_d;
            vend_item_q <= vend_item_d;
            coin_rej_q  <= coin_rej_d;
            chg_vld_q   <= chg_vld_d;
            chg_sel_q   <= chg_sel_d;
            buzzer_q    <= buzzer_d;
        end
    end

    vend_bin2bcd #(.BIN_W(PRICE_W)) u_bcd (
        .bin_i (credit_q),
        .bcd_o (credit_bcd)
    );

    assign credit    = credit_q;
    assign vend_vld  = vend_vld_q;
    assign vend_item = vend_item_q;
    assign coin_rej  = coin_rej_q;
    assign chg_vld   = chg_vld_q;
    assign chg_sel   = chg_sel_q;
    assign buzzer_en = buzzer_q;
    assign state_led = state_q;

endmodule

// File: tb/tb_vending_fsm_gen.sv
// tb/tb_vending_fsm_gen.sv - directed self-checking bench for vending_fsm_gen
module tb_vending_fsm_gen;

    logic       clk, rst;
    logic       coin_vld, buy, cancel, chg_ack;
    logic [1:0] coin_sel;
    logic [2:0] item_sel;
    logic [7:0] credit, credit_bcd;
    logic       vend_vld, coin_rej, chg_vld;
    logic [2:0] vend_item;
    logic [1:0] chg_sel, buzzer_en;
    logic [3:0] state_led;

    int n_chk  = 0;
    int n_fail = 0;

    vending_fsm_gen #(
        .NUM_ITEMS   (6),
        .PRICE_W     (8),
        .PRICES      ({8'd4, 8'd25, 8'd20, 8'd12, 8'd7, 8'd3}),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_vld   (coin_vld),
        .coin_sel   (coin_sel),
        .buy        (buy),
        .item_sel   (item_sel),
        .cancel     (cancel),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .credit_bcd (credit_bcd),
        .vend_vld   (vend_vld),
        .vend_item  (vend_item),
        .coin_rej   (coin_rej),
        .chg_vld    (chg_vld),
        .chg_sel    (chg_sel),
        .buzzer_en  (buzzer_en),
        .state_led  (state_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic coin(input logic [1:0] sel);
        coin_vld = 1'b1;
        coin_sel = sel;
        @(negedge clk);
        coin_vld = 1'b0;
    endtask

    task automatic buy_p(input logic [2:0] item);
        buy      = 1'b1;
        item_sel = item;
        @(negedge clk);
        buy = 1'b0;
    endtask

    task automatic cancel_p();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic ack_p();
        chg_ack = 1'b1;
        @(negedge clk);
        chg_ack = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_cycles);
        int n;
        n = 0;
        chg_ack = 1'b1;
        while (chg_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        chg_ack = 1'b0;
        chk({tag, "_cycles"}, n, exp_cycles);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_state"}, state_led, 4'b0001);
    endtask

    initial begin
        rst = 1'b1; coin_vld = 0; coin_sel = 0; buy = 0; item_sel = 0; cancel = 0; chg_ack = 0;
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_bcd", credit_bcd, 0);
        chk("rst_chg_vld", chg_vld, 0);
        chk("rst_vend_vld", vend_vld, 0);
        chk("rst_buzzer", buzzer_en, 0);
        chk("rst_state", state_led, 4'b0001);
        rst = 1'b0;
        tick();

        // Two COIN1 then buy item 1 (price 7): change of 3 in COIN0
        coin(2'd1);
        chk("t1_credit5", credit, 5);
        chk("t1_state_credit", state_led, 4'b0010);
        chk("t1_bcd5", credit_bcd, 8'h05);
        coin(2'd1);
        chk("t1_credit10", credit, 10);
        chk("t1_bcd10", credit_bcd, 8'h10);
        buy_p(3'd1);
        chk("t1_state_vend", state_led, 4'b1000);
        chk("t1_no_vend_yet", vend_vld, 0);
        tick();
        chk("t1_vend_vld", vend_vld, 1);
        chk("t1_vend_item", vend_item, 1);
        chk("t1_buzz_ok", buzzer_en, 2'b01);
        chk("t1_credit3", credit, 3);
        chk("t1_state_change", state_led, 4'b0100);
        chk("t1_chg_vld", chg_vld, 1);
        chk("t1_chg_sel", chg_sel, 0);
        ack_p();
        chk("t1_vend_drop", vend_vld, 0);
        chk("t1_credit2", credit, 2);
        chk("t1_sel_a", chg_sel, 0);
        ack_p();
        chk("t1_credit1", credit, 1);
        ack_p();
        chk("t1_credit0", credit, 0);
        chk("t1_chg_low", chg_vld, 0);
        chk("t1_idle", state_led, 4'b0001);
        ack_p();
        chk("t1_stray_ack", credit, 0);

        // Credit ceiling: 95 + 10 rejected, 95 + 1 accepted, invalid selector rejected
        for (int i = 0; i < 9; i++) coin(2'd2);
        coin(2'd1);
        chk("t2_credit95", credit, 95);
        chk("t2_bcd95", credit_bcd, 8'h95);
        coin(2'd2);
        chk("t2_rej", coin_rej, 1);
        chk("t2_buzz_err", buzzer_en, 2'b10);
        chk("t2_hold95", credit, 95);
        tick();
        chk("t2_rej_pulse", coin_rej, 0);
        coin(2'd0);
        chk("t2_credit96", credit, 96);
        chk("t2_rej_none", coin_rej, 0);
        coin(2'd3);
        chk("t2_inv_rej", coin_rej, 1);
        chk("t2_inv_hold", credit, 96);
        cancel_p();
        chk("t2_chg_sel2", chg_sel, 2);
        drain("t2_drain", 11);

        // Insufficient credit, out-of-range item, then item 5 (price 4) accepted
        coin(2'd1);
        buy_p(3'd3);
        chk("t3_buzz_err", buzzer_en, 2'b10);
        chk("t3_credit5", credit, 5);
        chk("t3_state_credit", state_led, 4'b0010);
        buy_p(3'd6);
        chk("t3_oob_err", buzzer_en, 2'b10);
        chk("t3_oob_state", state_led, 4'b0010);
        buy_p(3'd5);
        chk("t3_state_vend", state_led, 4'b1000);
        tick();
        chk("t3_vend_item5", vend_item, 5);
        chk("t3_credit1", credit, 1);
        drain("t3_drain", 1);

        // Credit 16, cancel with ack held: 2,1,0 on consecutive cycles
        coin(2'd2); coin(2'd1); coin(2'd0);
        chk("t4_credit16", credit, 16);
        chg_ack = 1'b1;
        cancel_p();
        chk("t4_sel2", chg_sel, 2);
        chk("t4_c16", credit, 16);
        tick();
        chk("t4_sel1", chg_sel, 1);
        chk("t4_c6", credit, 6);
        tick();
        chk("t4_sel0", chg_sel, 0);
        chk("t4_c1", credit, 1);
        tick();
        chk("t4_c0", credit, 0);
        chk("t4_chg_low", chg_vld, 0);
        chk("t4_idle", state_led, 4'b0001);
        chg_ack = 1'b0;

        // Timeout after 20 idle cycles, restarted by a coin at cycle 15
        coin(2'd2);
        for (int i = 0; i < 14; i++) tick();
        coin(2'd0);
        chk("t5_credit11", credit, 11);
        for (int i = 0; i < 19; i++) tick();
        chk("t5_still_credit", state_led, 4'b0010);
        tick();
        chk("t5_timeout_change", state_led, 4'b0100);
        chk("t5_chg_sel2", chg_sel, 2);
        drain("t5_drain", 2);

        // Buy and coin in the same cycle: vend wins, coin returned
        coin(2'd0); coin(2'd0); coin(2'd0);
        buy = 1'b1; item_sel = 3'd0; coin_vld = 1'b1; coin_sel = 2'd2;
        tick();
        buy = 1'b0; coin_vld = 1'b0;
        chk("t6_rej", coin_rej, 1);
        chk("t6_state_vend", state_led, 4'b1000);
        chk("t6_credit3", credit, 3);
        tick();
        chk("t6_vend", vend_vld, 1);
        chk("t6_item0", vend_item, 0);
        chk("t6_credit0", credit, 0);
        chk("t6_idle", state_led, 4'b0001);
        chk("t6_no_chg", chg_vld, 0);

        cancel_p();
        chk("t7_cancel0_state", state_led, 4'b0001);

        // Coin rejected in CHANGE, then asynchronous reset mid-change
        coin(2'd2);
        cancel_p();
        chk("t7_chg_vld", chg_vld, 1);
        coin(2'd0);
        chk("t7_chg_rej", coin_rej, 1);
        chk("t7_chg_hold", credit, 10);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_chg_vld", chg_vld, 0);
        chk("t7_rst_credit", credit, 0);
        chk("t7_rst_rej", coin_rej, 0);
        chk("t7_rst_state", state_led, 4'b0001);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_after_idle", state_led, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_fsm_gen.md
# vending_fsm_gen

Parametrised vending-machine controller, the next generation of the fixed-menu vending state block. Supports NUM_ITEMS products with a per-item price table, three parametrised coin denominations, credit saturation with coin rejection, an inactivity-timeout refund and handshaked greedy change dispensing. It sits between the key-debounce stage (one-cycle command pulses) and the seg_driver/buzzer_ctrl back end (BCD credit display, buzzer request code).

## Interface
- NUM_ITEMS, 4: number of products (≥1); ITEM_W = max(1, $clog2(NUM_ITEMS))
- PRICE_W, 8: width of price/credit in coin units
- PRICES, {8'd20,8'd12,8'd7,8'd3}: packed NUM_ITEMS×PRICE_W price table, item 0 in LSBs, each price ≥1
- COIN0 / COIN1 / COIN2, 1 / 5 / 10: denominations; COIN0 must equal 1; COIN0 < COIN1 < COIN2
- CREDIT_MAX, 99: credit ceiling; ≤99 and < 2^PRICE_W
- TIMEOUT_CYC, 500_000_000: idle cycles in CREDIT before auto-refund
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- coin_vld  in  1  one-cycle coin-insert pulse
- coin_sel  in  2  denomination of coin_vld: 0/1/2 → COIN0/1/2; 3 is invalid
- buy  in  1  one-cycle purchase pulse
- item_sel  in  ITEM_W  item for buy, sampled with buy
- cancel  in  1  one-cycle refund request
- chg_ack  in  1  coin-hopper acknowledge for the presented change coin
- credit  out  PRICE_W  current credit
- credit_bcd  out  8  credit as two BCD digits, tens in [7:4]
- vend_vld  out  1  one-cycle dispense pulse
- vend_item  out  ITEM_W  item being dispensed, valid with vend_vld
- coin_rej  out  1  one-cycle pulse: coin returned without crediting
- chg_vld  out  1  change coin presented
- chg_sel  out  2  denomination presented, stable while chg_vld is high
- buzzer_en  out  2  one-cycle request: 00 none, 01 vend success, 10 error
- state_led  out  4  one-hot state: IDLE[0], CREDIT[1], CHANGE[2], VEND[3]

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. Reset → IDLE; all outputs 0, credit 0, timer 0.
- IDLE/CREDIT, evaluated with priority cancel > buy > coin_vld:
  - cancel with credit>0 → CHANGE; with credit=0 it is ignored.
  - buy with item_sel ≥ NUM_ITEMS or credit < PRICES[item_sel]: buzzer_en=10, state and credit unchanged.
  - buy otherwise → VEND.
  - Valid coin with credit+value ≤ CREDIT_MAX: credit += value, IDLE → CREDIT.
  - coin_sel=3 or credit+value > CREDIT_MAX: coin_rej=1 and buzzer_en=10, credit unchanged.
  - A coin arriving in the same cycle as an accepted cancel or buy is rejected (coin_rej=1).
- VEND, exactly one cycle:
  - vend_vld=1, vend_item = latched item_sel, buzzer_en=01, credit −= price.
  - Next state: CHANGE if the remainder is >0, otherwise IDLE.
- CHANGE:
  - chg_sel is the largest denomination ≤ credit; chg_vld=1.
  - On chg_ack, credit −= that denomination. Credit reaching 0 → IDLE with chg_vld low the same cycle.
  - chg_ack while chg_vld=0 is ignored.
- In VEND/CHANGE, coin_vld → coin_rej; buy and cancel are ignored.
- Timeout: a counter runs in CREDIT and clears on any input pulse or state change. Reaching TIMEOUT_CYC−1 → CHANGE.
- Arithmetic: all sums are computed at PRICE_W+1 bits before the compare, so there is no wrap-around.

## Timing
- All outputs are registered. Effects appear the cycle after the input pulse (credit, coin_rej, buzzer_en, state).
- buy → vend_vld: 2 cycles (accept, then VEND).
- chg_ack → next chg_sel/credit update: 1 cycle. A hopper may hold chg_ack high to take one coin per cycle.
- credit_bcd is a combinational conversion of the registered credit, valid in the same cycle as credit.
- Reset mid-CHANGE clears credit. Outstanding change is forfeited and chg_vld drops asynchronously.

## Structure
- Package vending_pkg: state enum encoding, buzzer codes (BZ_NONE/BZ_OK/BZ_ERR), coin_sel encoding, ITEM_W function.
- Sub-module vend_bin2bcd: PRICE_W-bit binary → 2-digit BCD, combinational, reused by seg_driver feeds.
- The timeout counter width is $clog2(TIMEOUT_CYC). Benches override TIMEOUT_CYC=20.

## Test plan
- Insert COIN1, COIN1, then buy item 1 (price 7) → credit 5, 10, then vend_vld with vend_item=1, buzzer_en=01, then chg_sel=COIN2?no: credit 3 → chg_sel=0 presented three times, credit 3→2→1→0, then IDLE.
- Credit 95, insert COIN2 → coin_rej=1, buzzer_en=10, credit stays 95. Insert COIN0 → credit 96.
- Credit 5, buy item 3 (price 20) → buzzer_en=10, credit 5, state CREDIT. buy item_sel=5 with NUM_ITEMS=6 override, price table sized → accepted per table.
- Credit 16, cancel with chg_ack held high → chg_sel sequence 2,1,0 on consecutive cycles, credit 16→6→1→0, then IDLE.
- TIMEOUT_CYC=20, credit 10, no input → CHANGE entered 20 cycles after the last coin. A coin at cycle 15 restarts the count.
- buy item 0 and coin_vld COIN2 in the same cycle at credit 3 → vend proceeds, coin_rej=1, final credit 0. Assert rst during CHANGE → all outputs 0 immediately.
